// File: rtl/ysyx_22040365_pkg.sv
// ysyx_22040365_pkg
// Shared types and constants for the ysyx_22040365 core:
//   XLEN      - datapath width
//   NREG      - number of architectural integer registers
//   REG_ZERO  - index of the hard-wired zero register
//   ex_payload_t    - fields carried from operand fetch to execute
//   wb_hit()        - same-cycle write-back match on a register index
//   select_operand() - operand value with write-back forwarding
package ysyx_22040365_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        reg_idx_t        rd;
        logic            rd_wen;
    } ex_payload_t;

    // A retiring write-back targets r this cycle. x0 never matches since
    // nothing is ever pending on it.
    function automatic logic wb_hit(input logic     wb_valid,
                                    input reg_idx_t wb_rd,
                                    input reg_idx_t r);
        return wb_valid && (wb_rd == r) && (r != REG_ZERO);
    endfunction

    // Unused or x0 sources read as zero; a same-cycle write-back wins over
    // the (stale) register file contents.
    function automatic logic [XLEN-1:0] select_operand(input logic            ren,
                                                       input reg_idx_t        rs,
                                                       input logic            wb_valid,
                                                       input reg_idx_t        wb_rd,
                                                       input logic [XLEN-1:0] wb_data,
                                                       input logic [XLEN-1:0] rf_rdata);
        if (!ren || rs == REG_ZERO) begin
            return '0;
        end
        if (wb_hit(wb_valid, wb_rd, rs)) begin
            return wb_data;
        end
        return rf_rdata;
    endfunction

endpackage

// File: rtl/ysyx_22040365_operand_fetch_if.sv
// ysyx_22040365_operand_fetch_if
// Bundle of every bus the operand-fetch stage talks to:
//   decode     : id_valid/id_ready handshake and instruction fields
//   reg file   : read address/enable/data, write enable/address/data
//   write-back : wb_valid, wb_rd, wb_data
//   execute    : ex_valid/ex_ready handshake and registered fields
//   control    : flush in, stall_cnt out
// Modports:
//   slave  - the operand-fetch stage itself
//   master - its surroundings (decode, register file, write-back, execute)
interface ysyx_22040365_operand_fetch_if
    import ysyx_22040365_pkg::*;
#(
    parameter int W = XLEN
) ();

    // decode side
    logic         id_valid;
    logic         id_ready;
    logic [W-1:0] id_pc;
    reg_idx_t     id_rs1;
    reg_idx_t     id_rs2;
    logic         id_ren_rs1;
    logic         id_ren_rs2;
    reg_idx_t     id_rd;
    logic         id_rd_wen;

    // register file read ports
    reg_idx_t     rf_raddr1;
    reg_idx_t     rf_raddr2;
    logic         rf_ren1;
    logic         rf_ren2;
    logic [W-1:0] rf_rdata1;
    logic [W-1:0] rf_rdata2;

    // write-back and register file write port
    logic         wb_valid;
    reg_idx_t     wb_rd;
    logic [W-1:0] wb_data;
    logic         rf_wen;
    reg_idx_t     rf_waddr;
    logic [W-1:0] rf_wdata;

    // execute side
    logic         ex_valid;
    logic         ex_ready;
    logic [W-1:0] ex_pc;
    logic [W-1:0] ex_src1;
    logic [W-1:0] ex_src2;
    reg_idx_t     ex_rd;
    logic         ex_rd_wen;

    // control / status
    logic         flush;
    logic [31:0]  stall_cnt;

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_ren_rs1, id_ren_rs2, id_rd, id_rd_wen,
        output id_ready,
        output rf_raddr1, rf_raddr2, rf_ren1, rf_ren2,
        input  rf_rdata1, rf_rdata2,
        input  wb_valid, wb_rd, wb_data,
        output rf_wen, rf_waddr, rf_wdata,
        output ex_valid, ex_pc, ex_src1, ex_src2, ex_rd, ex_rd_wen,
        input  ex_ready,
        input  flush,
        output stall_cnt
    );

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_ren_rs1, id_ren_rs2, id_rd, id_rd_wen,
        input  id_ready,
        input  rf_raddr1, rf_raddr2, rf_ren1, rf_ren2,
        output rf_rdata1, rf_rdata2,
        output wb_valid, wb_rd, wb_data,
        input  rf_wen, rf_waddr, rf_wdata,
        input  ex_valid, ex_pc, ex_src1, ex_src2, ex_rd, ex_rd_wen,
        output ex_ready,
        output flush,
        input  stall_cnt
    );

endinterface

// File: rtl/ysyx_22040365_scoreboard.sv
// ysyx_22040365_scoreboard
// Busy scoreboard: one bit per architectural register, set when an
// instruction that writes it is issued and cleared on its write-back or
// when it is flushed from the output register before execute takes it.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   rs1/rs2, ren1/ren2  - source query of the instruction in decode
//   rd, rd_wen          - destination query of the instruction in decode
//   wb_valid, wb_rd     - retiring write-back (clears, and forwards)
//   kill_en, kill_idx   - clear for a flushed, not-yet-executed writer
//   set_en, set_idx     - mark a newly issued writer
//   hazard              - RAW on either source or WAW on the destination
module ysyx_22040365_scoreboard
    import ysyx_22040365_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs1,
    input  reg_idx_t rs2,
    input  logic     ren1,
    input  logic     ren2,
    input  reg_idx_t rd,
    input  logic     rd_wen,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd,
    input  logic     kill_en,
    input  reg_idx_t kill_idx,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    output logic     hazard
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            raw1;
    logic            raw2;
    logic            waw;

    // A pending register that is being written back this very cycle is not a
    // hazard: its value is forwarded, and a new writer may follow it.
    always_comb begin
        raw1   = ren1 && (rs1 != REG_ZERO) && busy[rs1] && !wb_hit(wb_valid, wb_rd, rs1);
        raw2   = ren2 && (rs2 != REG_ZERO) && busy[rs2] && !wb_hit(wb_valid, wb_rd, rs2);
        waw    = rd_wen && (rd != REG_ZERO) && busy[rd] && !wb_hit(wb_valid, wb_rd, rd);
        hazard = raw1 || raw2 || waw;
    end

    // Clears first, set last, so a new writer keeps its bit even when an
    // older write to the same register retires in the same cycle.
    always_comb begin
        // NOTE: start from the current value so every path assigns busy_next
        // and no latch is inferred.
        busy_next = busy;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (kill_en) begin
            busy_next[kill_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: rtl/ysyx_22040365_operand_fetch.sv
// ysyx_22040365_operand_fetch
// Operand-fetch stage between decode and execute. Reads both source
// operands from the register file, forwards a same-cycle write-back over
// the register file data, stalls decode on RAW/WAW hazards through the busy
// scoreboard, and holds the result in a valid/ready register toward execute.
// Ports:
//   clk  - core clock, all state on posedge
//   rst  - asynchronous, active-high reset
//   bus  - slave side of ysyx_22040365_operand_fetch_if (decode, register
//          file, write-back, execute, flush and stall_cnt)
module ysyx_22040365_operand_fetch
    import ysyx_22040365_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22040365_operand_fetch_if.slave   bus
);

    logic            hazard;
    logic            accept;
    logic            set_en;
    logic            kill_en;
    logic            ex_valid_q;
    ex_payload_t     ex_q;
    ex_payload_t     ex_d;
    logic [31:0]     stall_cnt_q;

    // Register file read side is a straight pass-through of decode.
    assign bus.rf_raddr1 = bus.id_rs1;
    assign bus.rf_raddr2 = bus.id_rs2;
    assign bus.rf_ren1   = bus.id_ren_rs1;
    assign bus.rf_ren2   = bus.id_ren_rs2;

    // Writes to x0 are dropped at the register file port.
    assign bus.rf_wen    = bus.wb_valid && (bus.wb_rd != REG_ZERO);
    assign bus.rf_waddr  = bus.wb_rd;
    assign bus.rf_wdata  = bus.wb_data;

    // The output register can take a new instruction when it is empty or is
    // being drained this cycle; flush always blocks the load.
    assign bus.id_ready = !bus.flush && !hazard && (!ex_valid_q || bus.ex_ready);
    assign accept       = bus.id_valid && bus.id_ready;

    assign set_en  = accept && bus.id_rd_wen && (bus.id_rd != REG_ZERO);
    // Only a writer still sitting in the output register is killed; anything
    // execute has already taken releases its bit on write-back.
    assign kill_en = bus.flush && ex_valid_q && ex_q.rd_wen;

    ysyx_22040365_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rs1      (bus.id_rs1),
        .rs2      (bus.id_rs2),
        .ren1     (bus.id_ren_rs1),
        .ren2     (bus.id_ren_rs2),
        .rd       (bus.id_rd),
        .rd_wen   (bus.id_rd_wen),
        .wb_valid (bus.wb_valid),
        .wb_rd    (bus.wb_rd),
        .kill_en  (kill_en),
        .kill_idx (ex_q.rd),
        .set_en   (set_en),
        .set_idx  (bus.id_rd),
        .hazard   (hazard)
    );

    always_comb begin
        ex_d.pc     = bus.id_pc;
        ex_d.src1   = select_operand(bus.id_ren_rs1, bus.id_rs1, bus.wb_valid,
                                     bus.wb_rd, bus.wb_data, bus.rf_rdata1);
        ex_d.src2   = select_operand(bus.id_ren_rs2, bus.id_rs2, bus.wb_valid,
                                     bus.wb_rd, bus.wb_data, bus.rf_rdata2);
        ex_d.rd     = bus.id_rd;
        ex_d.rd_wen = bus.id_rd_wen;
    end

    // Payload only moves on accept, which keeps it stable while execute is
    // back-pressuring and keeps the last value after it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_q       <= ex_d;
        end else if (bus.ex_ready || bus.flush) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Counts cycles decode was held back by a hazard; back-pressure from
    // execute or a flush alone does not count. Wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (bus.id_valid && hazard) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_pc     = ex_q.pc;
    assign bus.ex_src1   = ex_q.src1;
    assign bus.ex_src2   = ex_q.src2;
    assign bus.ex_rd     = ex_q.rd;
    assign bus.ex_rd_wen = ex_q.rd_wen;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22040365_operand_fetch.sv
// tb_ysyx_22040365_operand_fetch
// Directed scenarios with literal expectations followed by randomized
// traffic. A behavioural model (busy bit-set, expected execute entry, stall
// count) runs alongside the DUT and a single compare process checks every
// output on each falling edge.
module tb_ysyx_22040365_operand_fetch;
    import ysyx_22040365_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    always #5 clk = ~clk;

    ysyx_22040365_operand_fetch_if bus ();

    ysyx_22040365_operand_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]   m_busy;
    bit          m_ex_valid;
    ex_payload_t m_ex;
    logic [31:0] m_stall;

    function automatic bit m_hit(input logic [4:0] r);
        return bus.wb_valid && bus.wb_rd == r && r != 5'd0;
    endfunction

    function automatic bit m_pending(input bit used, input logic [4:0] r);
        return used && r != 5'd0 && m_busy[r] && !m_hit(r);
    endfunction

    function automatic bit m_hazard();
        return m_pending(bus.id_ren_rs1, bus.id_rs1) || m_pending(bus.id_ren_rs2, bus.id_rs2)
            || m_pending(bus.id_rd_wen, bus.id_rd);
    endfunction

    function automatic bit m_ready();
        return !bus.flush && !m_hazard() && (!m_ex_valid || bus.ex_ready);
    endfunction

    function automatic logic [63:0] m_opnd(input bit used, input logic [4:0] r, input logic [63:0] rdata);
        if (!used || r == 5'd0) return 64'd0;
        if (m_hit(r)) return bus.wb_data;
        return rdata;
    endfunction

    function automatic bit [31:0] m_busy_after(input bit acc);
        bit [31:0] b = m_busy;
        if (bus.wb_valid) b[bus.wb_rd] = 1'b0;
        if (bus.flush && m_ex_valid && m_ex.rd_wen) b[m_ex.rd] = 1'b0;
        if (acc && bus.id_rd_wen && bus.id_rd != 5'd0) b[bus.id_rd] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     <= '0;
            m_ex_valid <= 1'b0;
            m_ex       <= '0;
            m_stall    <= '0;
        end else begin
            m_busy <= m_busy_after(bus.id_valid && m_ready());
            if (bus.id_valid && m_ready()) begin
                m_ex_valid  <= 1'b1;
                m_ex.pc     <= bus.id_pc;
                m_ex.src1   <= m_opnd(bus.id_ren_rs1, bus.id_rs1, bus.rf_rdata1);
                m_ex.src2   <= m_opnd(bus.id_ren_rs2, bus.id_rs2, bus.rf_rdata2);
                m_ex.rd     <= bus.id_rd;
                m_ex.rd_wen <= bus.id_rd_wen;
            end else if (bus.ex_ready || bus.flush) begin
                m_ex_valid <= 1'b0;
            end
            if (bus.id_valid && m_hazard()) m_stall <= m_stall + 32'd1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("m_id_ready",  bus.id_ready,  m_ready());
            check("m_rf_raddr1", bus.rf_raddr1, bus.id_rs1);
            check("m_rf_raddr2", bus.rf_raddr2, bus.id_rs2);
            check("m_rf_ren1",   bus.rf_ren1,   bus.id_ren_rs1);
            check("m_rf_ren2",   bus.rf_ren2,   bus.id_ren_rs2);
            check("m_rf_wen",    bus.rf_wen,    bus.wb_valid && bus.wb_rd != 5'd0);
            check("m_rf_waddr",  bus.rf_waddr,  bus.wb_rd);
            check("m_rf_wdata",  bus.rf_wdata,  bus.wb_data);
            check("m_ex_valid",  bus.ex_valid,  m_ex_valid);
            check("m_ex_pc",     bus.ex_pc,     m_ex.pc);
            check("m_ex_src1",   bus.ex_src1,   m_ex.src1);
            check("m_ex_src2",   bus.ex_src2,   m_ex.src2);
            check("m_ex_rd",     bus.ex_rd,     m_ex.rd);
            check("m_ex_rd_wen", bus.ex_rd_wen, m_ex.rd_wen);
            check("m_stall_cnt", bus.stall_cnt, m_stall);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input logic [63:0] pc, input logic [4:0] rs1, input bit ren1,
                          input logic [4:0] rs2, input bit ren2, input logic [4:0] rd, input bit wen);
        bus.id_valid   = v;
        bus.id_pc      = pc;
        bus.id_rs1     = rs1;
        bus.id_ren_rs1 = ren1;
        bus.id_rs2     = rs2;
        bus.id_ren_rs2 = ren2;
        bus.id_rd      = rd;
        bus.id_rd_wen  = wen;
    endtask

    task automatic set_wb(input bit v, input logic [4:0] rd, input logic [63:0] data);
        bus.wb_valid = v;
        bus.wb_rd    = rd;
        bus.wb_data  = data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        bus.rf_rdata1 = '0;
        bus.rf_rdata2 = '0;
        bus.ex_ready  = 1'b1;
        bus.flush     = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        rst = 1'b1;
        #1;
        check("rst_ex_valid",  bus.ex_valid,  0);
        check("rst_ex_pc",     bus.ex_pc,     0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        check("rst_id_ready",  bus.id_ready,  1);
        step();
        rst = 1'b0;
        cmp_en = 1'b1;

        // Back-to-back independent writers, then readers of x1/x2/x3.
        set_id(1, 64'h100, 0, 0, 0, 0, 1, 1);
        at_neg();
        check("b2b_ready_a", bus.id_ready, 1);
        step();
        set_id(1, 64'h104, 0, 0, 0, 0, 2, 1);
        at_neg();
        check("b2b_ready_b", bus.id_ready, 1);
        check("b2b_ex_pc_a", bus.ex_pc, 64'h100);
        step();
        set_id(1, 64'h108, 1, 1, 0, 0, 0, 0);
        at_neg();
        check("busy_x1_stall", bus.id_ready, 0);
        check("b2b_ex_pc_b", bus.ex_pc, 64'h104);
        check("b2b_ex_valid_b", bus.ex_valid, 1);
        step();
        set_id(1, 64'h108, 0, 0, 2, 1, 0, 0);
        at_neg();
        check("busy_x2_stall", bus.id_ready, 0);
        step();
        set_id(1, 64'h10c, 3, 1, 0, 0, 3, 0);
        at_neg();
        check("x3_not_busy", bus.id_ready, 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(1, 1, 64'h11);
        step();
        set_wb(1, 2, 64'h22);
        step();
        set_wb(0, 0, 0);
        set_id(1, 64'h110, 1, 1, 2, 1, 0, 0);
        at_neg();
        check("after_wb_ready", bus.id_ready, 1);
        check("b2b_stall_cnt", bus.stall_cnt, 2);
        step();

        // RAW on x5 resolved by a same-cycle write-back.
        do_reset();
        set_id(1, 64'h200, 0, 0, 0, 0, 5, 1);
        step();
        set_id(1, 64'h204, 5, 1, 0, 0, 6, 1);
        bus.rf_rdata1 = 64'h1111;
        at_neg();
        check("raw_stall_ready", bus.id_ready, 0);
        step();
        at_neg();
        check("raw_stall_cnt1", bus.stall_cnt, 1);
        step();
        set_wb(1, 5, 64'hDEAD);
        at_neg();
        check("fwd_ready", bus.id_ready, 1);
        check("raw_stall_cnt2", bus.stall_cnt, 2);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        at_neg();
        check("fwd_ex_src1", bus.ex_src1, 64'hDEAD);
        check("fwd_ex_pc", bus.ex_pc, 64'h204);
        check("fwd_ex_rd", bus.ex_rd, 6);

        // x0 source reads zero; writes to x0 never mark busy.
        do_reset();
        bus.rf_rdata1 = 64'hFFFF;
        set_id(1, 64'h300, 0, 1, 0, 0, 0, 1);
        at_neg();
        check("x0_ready", bus.id_ready, 1);
        step();
        set_id(1, 64'h304, 0, 1, 0, 0, 0, 1);
        at_neg();
        check("x0_src1", bus.ex_src1, 0);
        check("x0_no_waw", bus.id_ready, 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg();
        check("x0_stall_cnt", bus.stall_cnt, 0);

        // Execute back-pressure holds the entry stable.
        do_reset();
        set_id(1, 64'h400, 0, 0, 0, 0, 8, 1);
        step();
        bus.ex_ready = 1'b0;
        set_id(1, 64'h404, 0, 0, 0, 0, 9, 1);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check("hold_ex_valid", bus.ex_valid, 1);
            check("hold_ex_pc", bus.ex_pc, 64'h400);
            check("hold_ex_rd", bus.ex_rd, 8);
            check("hold_id_ready", bus.id_ready, 0);
            step();
        end
        bus.ex_ready = 1'b1;
        at_neg();
        check("release_ready", bus.id_ready, 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        at_neg();
        check("release_ex_pc", bus.ex_pc, 64'h404);
        check("hold_stall_cnt", bus.stall_cnt, 0);

        // Flush of a held writer releases its busy bit.
        do_reset();
        bus.ex_ready = 1'b0;
        set_id(1, 64'h500, 0, 0, 0, 0, 7, 1);
        step();
        bus.flush = 1'b1;
        bus.rf_rdata1 = 64'h77;
        set_id(1, 64'h504, 7, 1, 0, 0, 0, 0);
        at_neg();
        check("flush_blocks", bus.id_ready, 0);
        check("flush_ex_rd", bus.ex_rd, 7);
        step();
        bus.flush = 1'b0;
        at_neg();
        check("flush_ex_valid", bus.ex_valid, 0);
        check("flush_unstalled", bus.id_ready, 1);
        step();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        bus.ex_ready = 1'b1;
        at_neg();
        check("flush_next_src1", bus.ex_src1, 64'h77);
        check("flush_next_pc", bus.ex_pc, 64'h504);

        // Asynchronous reset in the middle of a stall.
        do_reset();
        set_id(1, 64'h600, 0, 0, 0, 0, 3, 1);
        step();
        bus.ex_ready = 1'b0;
        set_id(1, 64'h604, 3, 1, 0, 0, 0, 0);
        step();
        at_neg();
        check("pre_rst_ex_valid", bus.ex_valid, 1);
        check("pre_rst_stall", bus.stall_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ex_valid", bus.ex_valid, 0);
        check("arst_stall", bus.stall_cnt, 0);
        check("arst_ex_pc", bus.ex_pc, 0);
        check("arst_id_ready", bus.id_ready, 1);
        step();
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            set_id($urandom_range(0, 9) < 8, {$urandom, $urandom},
                   5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                   5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            set_wb($urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            bus.rf_rdata1 = {$urandom, $urandom};
            bus.rf_rdata2 = {$urandom, $urandom};
            bus.ex_ready  = $urandom_range(0, 9) < 7;
            bus.flush     = $urandom_range(0, 19) == 0;
            step();
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
